// File: rtl/vga_timing_rx.sv
// VGA sync receiver: recovers pixel coordinates and data-enable from hsync/vsync,
// and verifies line/frame geometry before asserting locked.
module vga_timing_rx #(
   parameter int   HR       = 640,
   parameter int   HFP      = 16,
   parameter int   HBP      = 48,
   parameter int   HT       = 96,
   parameter int   VR       = 480,
   parameter int   VFP      = 10,
   parameter int   VBP      = 33,
   parameter int   VT       = 2,
   parameter logic SYNC_POL = 1'b0
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic       pix_en,
   input  logic       hsync,
   input  logic       vsync,
   output logic [9:0] x_pos,
   output logic [9:0] y_pos,
   output logic       de,
   output logic       locked,
   output logic       frame_start,
   output logic       timing_err
);
   localparam logic [10:0] H_TOTAL = 11'(HT + HBP + HR + HFP);
   localparam logic [10:0] V_TOTAL = 11'(VT + VBP + VR + VFP);
   localparam logic [9:0]  H_ACT0  = 10'(HT + HBP);
   localparam logic [9:0]  H_ACT1  = 10'(HT + HBP + HR);
   localparam logic [9:0]  V_ACT0  = 10'(VT + VBP);
   localparam logic [9:0]  V_ACT1  = 10'(VT + VBP + VR);
   localparam logic [9:0]  CNT_MAX = 10'h3FF;

   localparam logic [1:0] ST_SEARCH = 2'd0;
   localparam logic [1:0] ST_VERIFY = 2'd1;
   localparam logic [1:0] ST_LOCKED = 2'd2;

   logic        hs_act, vs_act, hs_lead, vs_lead;
   logic        timeout, line_bad, frame_bad;
   logic [10:0] line_len, frame_len;

   logic        hs_prev_q, vs_prev_q;
   logic [9:0]  h_cnt_q, h_cnt_d, v_cnt_q, v_cnt_d;
   logic [1:0]  state_q, state_d;
   logic        flag_q, flag_d, seen_q, seen_d;
   logic        de_q, de_d, fs_q, fs_d, err_q, err_d;
   logic [9:0]  x_q, x_d, y_q, y_d;

   assign hs_act    = (hsync == SYNC_POL);
   assign vs_act    = (vsync == SYNC_POL);
   assign hs_lead   = hs_act & ~hs_prev_q;
   assign vs_lead   = vs_act & ~vs_prev_q;
   assign line_len  = {1'b0, h_cnt_q} + 11'd1;
   assign frame_len = {1'b0, v_cnt_q} + 11'd1;
   // Fires once, on the sample that carries h_cnt into saturation.
   assign timeout   = ~hs_lead & (h_cnt_q == CNT_MAX - 10'd1);
   // seen_q suppresses the check on the first edge, whose start point is unknown.
   assign line_bad  = hs_lead & seen_q & (line_len != H_TOTAL);
   assign frame_bad = (frame_len != V_TOTAL);

   always_comb begin
      h_cnt_d = h_cnt_q;
      v_cnt_d = v_cnt_q;
      state_d = state_q;
      flag_d  = flag_q;
      seen_d  = seen_q;
      de_d    = de_q;
      x_d     = x_q;
      y_d     = y_q;
      fs_d    = 1'b0;
      err_d   = 1'b0;
      if (pix_en) begin
         if (hs_lead)                 h_cnt_d = '0;
         else if (h_cnt_q != CNT_MAX) h_cnt_d = h_cnt_q + 10'd1;

         if (vs_lead)                            v_cnt_d = '0;
         else if (hs_lead && v_cnt_q != CNT_MAX) v_cnt_d = v_cnt_q + 10'd1;

         case (state_q)
            ST_SEARCH: begin
               if (vs_lead) begin
                  state_d = ST_VERIFY;
                  flag_d  = 1'b0;
               end
            end
            ST_VERIFY: begin
               if (timeout) begin
                  state_d = ST_SEARCH;
               end else if (vs_lead) begin
                  // The line closed by this edge still belongs to the frame being judged.
                  if (!flag_q && !line_bad && !frame_bad) state_d = ST_LOCKED;
                  flag_d = 1'b0;
               end else if (line_bad) begin
                  flag_d = 1'b1;
               end
            end
            ST_LOCKED: begin
               if (timeout || line_bad || (vs_lead && frame_bad)) begin
                  state_d = ST_SEARCH;
                  err_d   = 1'b1;
               end
            end
            default: state_d = ST_SEARCH;
         endcase

         seen_d = hs_lead | (seen_q & ~(state_d == ST_SEARCH && state_q != ST_SEARCH));

         de_d = (state_d == ST_LOCKED) &&
                (h_cnt_d >= H_ACT0) && (h_cnt_d < H_ACT1) &&
                (v_cnt_d >= V_ACT0) && (v_cnt_d < V_ACT1);
         x_d  = de_d ? h_cnt_d - H_ACT0 : '0;
         y_d  = de_d ? v_cnt_d - V_ACT0 : '0;
         fs_d = de_d && (x_d == '0) && (y_d == '0);
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         hs_prev_q <= 1'b0;
         vs_prev_q <= 1'b0;
         h_cnt_q   <= '0;
         v_cnt_q   <= '0;
         state_q   <= ST_SEARCH;
         flag_q    <= 1'b0;
         seen_q    <= 1'b0;
         de_q      <= 1'b0;
         x_q       <= '0;
         y_q       <= '0;
         fs_q      <= 1'b0;
         err_q     <= 1'b0;
      end else begin
         if (pix_en) begin
            hs_prev_q <= hs_act;
            vs_prev_q <= vs_act;
         end
         h_cnt_q <= h_cnt_d;
         v_cnt_q <= v_cnt_d;
         state_q <= state_d;
         flag_q  <= flag_d;
         seen_q  <= seen_d;
         de_q    <= de_d;
         x_q     <= x_d;
         y_q     <= y_d;
         fs_q    <= fs_d;
         err_q   <= err_d;
      end
   end

   assign x_pos       = x_q;
   assign y_pos       = y_q;
   assign de          = de_q;
   assign locked      = (state_q == ST_LOCKED);
   assign frame_start = fs_q;
   assign timing_err  = err_q;
endmodule
